// File: rtl/ac97_sic.sv
// AC97 serial input controller: deserializes SDATA_IN framed by SYNC and presents
// the slot 0 tag, slot 1/2 status, slot 1 SLOTREQ and slot 3/4 PCM record samples.
module ac97_sic (
   input  logic        clk,
   input  logic        rst,
   input  logic        sync,
   input  logic        sdata_in,
   output logic        codec_ready,
   output logic [6:0]  sts_addr,
   output logic [15:0] sts_data,
   output logic        sts_valid,
   output logic [9:0]  slot_req,
   output logic [19:0] pcm_l,
   output logic [19:0] pcm_r,
   output logic        pcm_l_valid,
   output logic        pcm_r_valid,
   output logic        frame_err
);

   typedef enum logic [1:0] {StIdle, StRecv, StWait} state_e;

   state_e      state_q, state_d;
   logic [7:0]  bit_cnt_q, bit_cnt_d;
   logic        sync_q;
   logic [18:0] shift_q, shift_d;
   logic [19:0] shift_nxt;
   logic        sync_rise;

   // Only tag bits 15..11 gate commits; slot 1 keeps bits 18:2, slot 2 keeps bits 19:4.
   logic [4:0]  tag_q, tag_d;
   logic [16:0] slot1_q, slot1_d;
   logic [15:0] slot2_q, slot2_d;
   logic [19:0] slot3_q, slot3_d;

   logic        codec_ready_q, codec_ready_d;
   logic [6:0]  sts_addr_q, sts_addr_d;
   logic [15:0] sts_data_q, sts_data_d;
   logic        sts_valid_q, sts_valid_d;
   logic [9:0]  slot_req_q, slot_req_d;
   logic [19:0] pcm_l_q, pcm_l_d;
   logic [19:0] pcm_r_q, pcm_r_d;
   logic        pcm_l_valid_q, pcm_l_valid_d;
   logic        pcm_r_valid_q, pcm_r_valid_d;
   logic        frame_err_q, frame_err_d;

   assign sync_rise = sync & ~sync_q;
   assign shift_nxt = {shift_q, sdata_in};

   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      tag_d         = tag_q;
      slot1_d       = slot1_q;
      slot2_d       = slot2_q;
      slot3_d       = slot3_q;
      codec_ready_d = codec_ready_q;
      sts_addr_d    = sts_addr_q;
      sts_data_d    = sts_data_q;
      slot_req_d    = slot_req_q;
      pcm_l_d       = pcm_l_q;
      pcm_r_d       = pcm_r_q;
      sts_valid_d   = 1'b0;
      pcm_l_valid_d = 1'b0;
      pcm_r_valid_d = 1'b0;
      frame_err_d   = 1'b0;

      case (state_q)
         StIdle, StWait: begin
            if (sync_rise) begin
               state_d   = StRecv;
               bit_cnt_d = 8'd1;
               shift_d   = shift_nxt[18:0];
            end
         end
         StRecv: begin
            shift_d = shift_nxt[18:0];
            if (sync_rise) begin
               // Early sync: drop the current frame, this edge carries bit 0.
               frame_err_d = 1'b1;
               bit_cnt_d   = 8'd1;
            end else begin
               bit_cnt_d = bit_cnt_q + 8'd1;
               case (bit_cnt_q)
                  8'd15: begin
                     tag_d         = shift_nxt[15:11];
                     codec_ready_d = shift_nxt[15];
                  end
                  8'd35: slot1_d = shift_nxt[18:2];
                  8'd55: slot2_d = shift_nxt[19:4];
                  8'd75: slot3_d = shift_nxt;
                  8'd95: begin
                     if (tag_q[4]) slot_req_d = slot1_q[9:0];
                     if (tag_q[4] & tag_q[3] & tag_q[2]) begin
                        sts_addr_d  = slot1_q[16:10];
                        sts_data_d  = slot2_q;
                        sts_valid_d = 1'b1;
                     end
                     if (tag_q[4] & tag_q[1]) begin
                        pcm_l_d       = slot3_q;
                        pcm_l_valid_d = 1'b1;
                     end
                     if (tag_q[4] & tag_q[0]) begin
                        pcm_r_d       = shift_nxt;
                        pcm_r_valid_d = 1'b1;
                     end
                  end
                  8'd255: state_d = StWait;
                  default: ;
               endcase
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= StIdle;
         bit_cnt_q     <= 8'd0;
         sync_q        <= 1'b1;
         shift_q       <= '0;
         tag_q         <= '0;
         slot1_q       <= '0;
         slot2_q       <= '0;
         slot3_q       <= '0;
         codec_ready_q <= 1'b0;
         sts_addr_q    <= '0;
         sts_data_q    <= '0;
         sts_valid_q   <= 1'b0;
         slot_req_q    <= '0;
         pcm_l_q       <= '0;
         pcm_r_q       <= '0;
         pcm_l_valid_q <= 1'b0;
         pcm_r_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         sync_q        <= sync;
         shift_q       <= shift_d;
         tag_q         <= tag_d;
         slot1_q       <= slot1_d;
         slot2_q       <= slot2_d;
         slot3_q       <= slot3_d;
         codec_ready_q <= codec_ready_d;
         sts_addr_q    <= sts_addr_d;
         sts_data_q    <= sts_data_d;
         sts_valid_q   <= sts_valid_d;
         slot_req_q    <= slot_req_d;
         pcm_l_q       <= pcm_l_d;
         pcm_r_q       <= pcm_r_d;
         pcm_l_valid_q <= pcm_l_valid_d;
         pcm_r_valid_q <= pcm_r_valid_d;
         frame_err_q   <= frame_err_d;
      end
   end

   assign codec_ready = codec_ready_q;
   assign sts_addr    = sts_addr_q;
   assign sts_data    = sts_data_q;
   assign sts_valid   = sts_valid_q;
   assign slot_req    = slot_req_q;
   assign pcm_l       = pcm_l_q;
   assign pcm_r       = pcm_r_q;
   assign pcm_l_valid = pcm_l_valid_q;
   assign pcm_r_valid = pcm_r_valid_q;
   assign frame_err   = frame_err_q;

endmodule

// File: doc/ac97_sic.md
# ac97_sic

AC97 serial input controller: the receive-side counterpart of the AC97 serial output controller. It runs on the bit clock and deserializes the codec's SDATA_IN stream, framed by the controller-generated SYNC. It extracts the slot 0 tag, the slot 1/2 status address/data, the slot 1 SLOTREQ bits, and the slot 3/4 PCM record samples. Captured fields are presented to the register/FIFO side with one-cycle valid strobes.

## Interface

- No parameters; widths are fixed by the AC97 frame format.
- clk  in  1  AC97 bit clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-low.
- sync  in  1  frame sync, as driven to the codec by the output controller. It is high for 16 bits at frame start.
- sdata_in  in  1  serial data from the codec, already registered, MSB first.
- codec_ready  out  1  tag bit 15 of the most recent frame.
- sts_addr  out  7  status register index, taken from slot 1 bits 18:12.
- sts_data  out  16  status data, taken from slot 2 bits 19:4.
- sts_valid  out  1  one-cycle pulse; sts_addr/sts_data updated this frame.
- slot_req  out  10  SLOTREQ, taken from slot 1 bits 11:2.
- pcm_l  out  20  left PCM record sample (slot 3).
- pcm_r  out  20  right PCM record sample (slot 4).
- pcm_l_valid  out  1  one-cycle pulse; pcm_l updated.
- pcm_r_valid  out  1  one-cycle pulse; pcm_r updated.
- frame_err  out  1  one-cycle pulse; sync rose before the previous frame's 256 bits were received.

## Operation

- Frame bit index b runs 0..255.
  - Slot 0: b = 0..15.
  - Slot n (n ≥ 1): b = 16+20(n-1) .. 35+20(n-1).
  - Slot 1 = 16..35, slot 2 = 36..55, slot 3 = 56..75, slot 4 = 76..95. Slots 5..12 are ignored.
- Sync rise means sync = 1 at this edge with sync_d = 0, where sync_d is a 1-cycle delayed copy of sync. sync_d resets to 1, so a frame already in progress at reset release is not accepted.
- Bit 0 is the sdata_in value sampled on the sync-rise edge. That edge loads bit_cnt <= 1.
- State machine:
  - IDLE (reset state): sync rise -> RECV.
  - RECV: sample bit bit_cnt, then bit_cnt++. After sampling b = 255 -> WAIT. Sync rise -> frame_err, restart at bit 0 and remain in RECV.
  - WAIT: bit_cnt holds and sdata_in is ignored. Sync rise -> RECV at bit 0.
- Frames stretched by the output controller's pause (gap after bit 255) are legal: the block simply stays in WAIT.
- Staging:
  - A 20-bit shift register collects bits MSB first.
  - The tag loads from {shift[14:0], sdata_in} on the b = 15 edge.
  - Slot 1, 2 and 3 stage registers load on b = 35, 55 and 75.
  - Slot 4 is taken directly from the shift path on b = 95.
- Commit happens on the b = 95 edge only, gated by the tag:
  - sts_addr/sts_data/sts_valid when tag[15] & tag[14] & tag[13].
  - slot_req when tag[15].
  - pcm_l/pcm_l_valid when tag[15] & tag[12].
  - pcm_r/pcm_r_valid when tag[15] & tag[11].
- Fields that are not committed hold their previous values.
- A frame aborted by frame_err before b = 95 commits nothing. Data already committed (abort after b = 95) stands.

## Timing

- Reset values:
  - All outputs 0.
  - State IDLE, bit_cnt 0, all stage registers 0, sync_d 1.
- codec_ready is registered from the b = 15 edge and visible the following cycle.
- Data outputs and valid strobes are registered from the b = 95 edge. They are visible in the next cycle, 96 cycles after the sync-rise edge.
- Valid strobes are high exactly 1 cycle, at most once per frame.
- frame_err is registered from the offending sync-rise edge and is high 1 cycle. The same edge captures bit 0 of the new frame.
- Nominal 256-cycle frames run back-to-back: WAIT lasts 0 cycles because the sync rise arrives on the edge after b = 255.
- Reset asserted mid-frame returns the block to IDLE within one edge. Valid strobes are not emitted, and the next sync rise after release starts clean.
- Sync staying high longer than 16 cycles is not checked. Only rising edges matter.

## Test plan

1. Reset, then a frame with tag 0xF800, slot1 = 0x26000, slot2 = 0x12340, slot3 = 0xABCDE, slot4 = 0x13579.
   - codec_ready = 1.
   - sts_addr = 0x26, sts_data = 0x1234, slot_req = 0x000.
   - pcm_l = 0xABCDE, pcm_r = 0x13579.
   - All three valids pulse for 1 cycle, 96 cycles after the sync rise.
2. Tag 0x9000 (ready + slot 3 only).
   - Only pcm_l_valid pulses.
   - sts_* and pcm_r hold their prior values.
   - slot_req updates from slot 1 bits 11:2 (e.g. slot1 = 0x00C00 -> slot_req = 0x300).
3. Tag 0x7800 (codec not ready).
   - No valid strobes and no output changes.
   - codec_ready = 0.
4. Sync rise at b = 60 of a frame.
   - frame_err pulses 1 cycle.
   - No commit for the aborted frame.
   - The following full frame commits normally.
5. Frame stretched by holding sync low for 1280 extra cycles after bit 255 (8 kHz pause).
   - No frame_err.
   - The next frame decodes correctly.
6. sync high at reset release.
   - No capture until the next 0->1 sync transition.
   - Reset asserted at b = 80 -> no valid strobes, and all outputs are 0 afterward.
